// File: rtl/ppu_ram_responder.sv
// Memory-side responder for the PPU nibble-serial RAM bus: captures a 16-bit address over a
// 4-cycle frame, reads a word and returns it nibble-serially READ_DELAY frames later.
// Optional read counter enabled by defining PPU_RAM_RESPONDER_STATS_EN.
module ppu_ram_responder #(
  parameter int RAM_PINS   = 4,
  parameter int ADDR_BITS  = 8,
  parameter int READ_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RAM_PINS-1:0]  addr_pins,
  output logic [RAM_PINS-1:0]  data_pins,
  input  logic                 resync,
  output logic [1:0]           phase,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [15:0]          wr_data,
  output logic [15:0]          read_count
);

  localparam int DLY = (READ_DELAY >= 1 && READ_DELAY <= 3) ? READ_DELAY : 1;

  logic [1:0]          phase_q, phase_d;
  logic [RAM_PINS-1:0] nib_q [3];
  logic [15:0]         mem [2**ADDR_BITS];
  logic [15:0]         full_addr;
  logic [15:0]         rd_word;
  logic [15:0]         load_word;
  logic [15:0]         shift_q, shift_d;
  logic                rd_fire;
  logic                wr_fire;

  // The read fires at the edge ending phase 3, so the host port is closed during that phase.
  assign rd_fire   = (phase_q == 2'd3);
  assign wr_ready  = !reset && (phase_q != 2'd3);
  assign wr_fire   = wr_valid && wr_ready;
  assign full_addr = {addr_pins, nib_q[2], nib_q[1], nib_q[0]};
  assign rd_word   = mem[full_addr[ADDR_BITS-1:0]];
  assign data_pins = shift_q[RAM_PINS-1:0];
  assign phase     = phase_q;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    phase_d = phase_q + 2'd1;
    shift_d = shift_q >> RAM_PINS;
    if (resync)  phase_d = 2'd0;
    if (rd_fire) shift_d = load_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 2'd0;
      shift_q <= '0;
      for (int i = 0; i < 3; i++) nib_q[i] <= '0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
      for (int i = 0; i < 3; i++) begin
        if (phase_q == 2'(i)) nib_q[i] <= addr_pins;
      end
    end
  end

  // NOTE: the word array has no reset; clearing it would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
  end

  if (DLY == 1) begin : g_no_pipe
    assign load_word = rd_word;
  end else begin : g_pipe
    logic [15:0] pipe_q [DLY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DLY-1; i++) pipe_q[i] <= '0;
      end else if (rd_fire) begin
        pipe_q[0] <= rd_word;
        for (int i = 1; i < DLY-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign load_word = pipe_q[DLY-2];
  end

  // High address bits alias onto the low ones.
  if (ADDR_BITS < 16) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^full_addr[15:ADDR_BITS];
  end

`ifdef PPU_RAM_RESPONDER_STATS_EN
  logic [15:0] read_count_q;

  always_ff @(posedge clk) begin
    if (reset)        read_count_q <= '0;
    else if (rd_fire) read_count_q <= read_count_q + 16'd1;
  end

  assign read_count = read_count_q;
`else
  assign read_count = '0;
`endif

endmodule

// File: doc/ppu_ram_responder.md
Name: ppu_ram_responder

Overview:
- Memory-side responder for the PPU's nibble-serial RAM interface.
- Deserializes 16-bit word addresses from the PPU's address pins, reads an internal word memory, and serializes the 16-bit result back on the PPU's data pins after a fixed, parameterized number of frames.
- A host write port with a valid/ready handshake loads the memory.
- Used as the RAM model in benches and in FPGA builds of the console.

Parameters:
- RAM_PINS, 4: width of the address and data pin buses. Only 4 is supported; 16-bit words use 4 nibbles.
- ADDR_BITS, 8: memory depth is 2^ADDR_BITS 16-bit words. Address bits [15:ADDR_BITS] are ignored, so the memory aliases.
- READ_DELAY, 1: frames between address capture and data return. Legal range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr_pins  in  RAM_PINS  address nibble from the PPU
- data_pins  out  RAM_PINS  data nibble to the PPU (registered)
- resync  in  1  forces the phase counter to 0 on the next edge
- phase  out  2  current frame phase, for debug and bench alignment
- wr_valid  in  1  host write request
- wr_ready  out  1  host write can be accepted this cycle
- wr_addr  in  ADDR_BITS  host write word address
- wr_data  in  16  host write data
- read_count  out  16  read transaction counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Frame: 4 cycles, phase p = 0,1,2,3. p is a free-running 2-bit counter: 0 on reset, 0 at the edge after resync=1, otherwise increments with wrap 3->0.
- Address capture: during phase k, addr_pins carries address nibble k, LSB nibble first. The edge ending phases 0..2 stores nibbles 0..2. The edge ending phase 3 forms the address {addr_pins, n2, n1, n0}, truncates it to ADDR_BITS, and reads the memory.
- Every frame is a read transaction. There is no idle encoding.
- Return path, READ_DELAY=1: at the edge ending phase 3, the read word loads the output shift register and data_pins <= word[3:0]. The edges ending phases 0, 1, 2 of the next frame output nibbles 1, 2, 3. So during phase k of frame N+1, data_pins = nibble k of the word addressed in frame N.
- Return path, READ_DELAY=D>1: the word passes through D-1 word registers advanced at each phase-3 edge. It appears on data_pins during frame N+D, one word per frame, back-to-back with no bubbles.
- Reset values: data_pins=0, phase=0, all pipeline words and the shift register 0, read_count=0. After reset, the first READ_DELAY frames output 0.
- Memory contents are not reset.
- Host write handshake:
  - wr_ready = !reset && (p != 3).
  - A write happens at an edge where wr_valid && wr_ready.
  - At p=3, wr_ready is 0, so a write never collides with a read. The host holds wr_valid, and the write is accepted at the edge ending the next phase 0.
  - A write accepted at the edge ending phase 2 is visible to the read at the edge ending phase 3 of the same frame.
- resync mid-frame: partially captured nibbles are discarded because no read fires for that frame. The pipeline and the shift register keep their contents. The shift register keeps shifting each cycle, and nibbles past index 3 output as 0 until the next phase-3 load.
- reset mid-frame clears everything listed above on that edge. Writes pending during reset are not accepted.
- Out-of-range READ_DELAY is treated as 1.

Optional Feature:
- Macro: PPU_RAM_RESPONDER_STATS_EN.
- Defined: read_count increments by 1 at every phase-3 edge, wraps at 16 bits, and is cleared by reset.
- Undefined: read_count is constant 0 and no counter logic is synthesized.

Test Plan:
- Preload mem[0x12]=0xBEEF, READ_DELAY=1. Drive addr nibbles 2,1,0,0 in frame 0 -> data_pins = F,E,E,B during phases 0..3 of frame 1.
- Aliasing, ADDR_BITS=8. Write mem[0x34]=0x1234. Request address 0xAB34 -> returns nibbles 4,3,2,1.
- Write/read ordering. Assert wr_valid at phase 3 -> wr_ready=0, write accepted at the edge ending phase 0. Write mem[5]=0xCAFE accepted at phase 2 while addr 0x0005 is presented -> the next frame returns E,F,A,C.
- READ_DELAY=3. Request addresses of three distinct preloaded words in frames 0,1,2 -> words appear in frames 3,4,5 in order, with data_pins=0 in frames 0..2.
- Reset asserted at phase 1 with the pipeline full -> data_pins=0 and phase=0 after the edge. The next return is valid only READ_DELAY frames after the first post-reset address.
- STATS_EN defined: 10 frames after reset -> read_count=10; undefined -> read_count stays 0.
